// File: rtl/ccx_pkg.sv
// Shared types and default sizing for the chunked compute unit.
package ccx_pkg;

  localparam int unsigned CCX_CHUNKSIZE = 4;
  localparam int unsigned CCX_XLEN      = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CALC = 2'd2,
    ST_SEND = 2'd3
  } ccx_state_e;

  typedef enum logic {
    CCX_OP_SATADD  = 1'b0,
    CCX_OP_HAMMING = 1'b1
  } ccx_op_e;

endpackage

// File: rtl/ccx_chunk_alu.sv
// Combinational operation datapath: saturating add or Hamming distance.
module ccx_chunk_alu
  import ccx_pkg::*;
#(
  parameter int unsigned XLEN = CCX_XLEN
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  ccx_op_e         op_i,
  output logic [XLEN-1:0] res_o
);

  localparam int unsigned PW = $clog2(XLEN + 1);

  logic [XLEN:0]   sum;
  logic [XLEN-1:0] diff;
  logic [PW-1:0]   pop;

  always_comb begin
    sum  = {1'b0, a_i} + {1'b0, b_i};
    diff = a_i ^ b_i;
    pop  = '0;
    for (int i = 0; i < int'(XLEN); i++) begin
      pop = pop + PW'(diff[i]);
    end
    res_o = '0;
    case (op_i)
      CCX_OP_SATADD:  res_o = sum[XLEN] ? '1 : sum[XLEN-1:0];
      CCX_OP_HAMMING: res_o = XLEN'(pop);
      default:        res_o = '0;
    endcase
  end

endmodule

// File: rtl/ccx_chunk_unit.sv
// Chunk-serial compute unit: gathers operands chunk by chunk, computes once,
// then streams the result back one chunk per cycle.
module ccx_chunk_unit
  import ccx_pkg::*;
#(
  parameter int unsigned CHUNKSIZE = CCX_CHUNKSIZE,
  parameter int unsigned XLEN      = CCX_XLEN
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [CHUNKSIZE-1:0] ccx_rs_a_i,
  input  logic [CHUNKSIZE-1:0] ccx_rs_b_i,
  input  logic [1:0]           ccx_sel_i,
  input  logic                 ccx_req_i,
  output logic [CHUNKSIZE-1:0] ccx_res_o,
  output logic                 ccx_resp_o
);

  localparam int unsigned NCHUNK = XLEN / CHUNKSIZE;
  localparam int unsigned CNTW   = $clog2(NCHUNK + 1);
  localparam int unsigned TOP    = XLEN - CHUNKSIZE;

  ccx_state_e           state_q, state_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  ccx_op_e              op_q, op_d;
  logic [XLEN-1:0]      a_q, a_d;
  logic [XLEN-1:0]      b_q, b_d;
  logic [XLEN-1:0]      res_q, res_d;
  logic [CHUNKSIZE-1:0] out_q, out_d;
  logic                 resp_q, resp_d;
  logic [XLEN-1:0]      alu_res;
  logic                 unused_sel_hi;

  assign unused_sel_hi = ccx_sel_i[1];

  ccx_chunk_alu #(.XLEN(XLEN)) u_alu (
    .a_i  (a_q),
    .b_i  (b_q),
    .op_i (op_q),
    .res_o(alu_res)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= CCX_OP_SATADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      out_q   <= '0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      out_q   <= out_d;
      resp_q  <= resp_d;
    end
  end

  // Operands shift in from the top so chunk 0 ends up in the LSBs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    out_d   = '0;
    resp_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ccx_req_i) begin
          a_d     = XLEN'(ccx_rs_a_i) << TOP;
          b_d     = XLEN'(ccx_rs_b_i) << TOP;
          op_d    = ccx_op_e'(ccx_sel_i[0]);
          cnt_d   = CNTW'(1);
          state_d = (NCHUNK == 1) ? ST_CALC : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (ccx_req_i) begin
          a_d   = (a_q >> CHUNKSIZE) | (XLEN'(ccx_rs_a_i) << TOP);
          b_d   = (b_q >> CHUNKSIZE) | (XLEN'(ccx_rs_b_i) << TOP);
          cnt_d = cnt_q + CNTW'(1);
          if (cnt_q == CNTW'(NCHUNK - 1)) begin
            cnt_d   = '0;
            state_d = ST_CALC;
          end
        end else begin
          a_d     = '0;
          b_d     = '0;
          cnt_d   = '0;
          op_d    = CCX_OP_SATADD;
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        // Chunk 0 goes straight to the output flop so SEND starts next cycle.
        res_d   = alu_res >> CHUNKSIZE;
        out_d   = alu_res[CHUNKSIZE-1:0];
        resp_d  = 1'b1;
        cnt_d   = CNTW'(1);
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (cnt_q == CNTW'(NCHUNK)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          out_d  = res_q[CHUNKSIZE-1:0];
          resp_d = 1'b1;
          res_d  = res_q >> CHUNKSIZE;
          cnt_d  = cnt_q + CNTW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ccx_res_o  = out_q;
  assign ccx_resp_o = resp_q;

endmodule

// File: tb/tb_ccx_chunk_unit.sv
// Scoreboard bench for ccx_chunk_unit (CHUNKSIZE=4, XLEN=32).
module tb_ccx_chunk_unit;

  localparam int CS = 4;
  localparam int XL = 32;
  localparam int NC = XL / CS;

  typedef struct {
    logic [CS-1:0] chunk;
    int            cyc;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [CS-1:0] rs_a;
  logic [CS-1:0] rs_b;
  logic [1:0]    sel;
  logic          req;
  logic [CS-1:0] res;
  logic          resp;

  int   cyc;
  int   n_tests;
  int   n_fail;
  exp_t sb_q[$];

  ccx_chunk_unit #(.CHUNKSIZE(CS), .XLEN(XL)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .ccx_rs_a_i(rs_a),
    .ccx_rs_b_i(rs_b),
    .ccx_sel_i (sel),
    .ccx_req_i (req),
    .ccx_res_o (res),
    .ccx_resp_o(resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [XL-1:0] model(input logic [XL-1:0] a, input logic [XL-1:0] b,
                                          input logic [1:0] s);
    logic [XL:0] sum;
    if (s[0]) return XL'($countones(a ^ b));
    sum = {1'b0, a} + {1'b0, b};
    return sum[XL] ? {XL{1'b1}} : sum[XL-1:0];
  endfunction

  // Output monitor: every valid chunk is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (resp) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_resp: resp=1 res=%h at cycle %0d, nothing expected", res, cyc);
        end else begin
          e = sb_q.pop_front();
          n_tests++;
          if (res !== e.chunk) begin
            n_fail++;
            $display("FAIL chunk_value: got %h expected %h at cycle %0d", res, e.chunk, cyc);
          end
          n_tests++;
          if (cyc !== e.cyc) begin
            n_fail++;
            $display("FAIL chunk_timing: chunk seen at cycle %0d expected cycle %0d", cyc, e.cyc);
          end
        end
      end else begin
        n_tests++;
        if (res !== '0) begin
          n_fail++;
          $display("FAIL idle_res_zero: res=%h while resp=0 at cycle %0d", res, cyc);
        end
      end
    end
  end

  // Drives one full transfer and queues the expected result chunks.
  task automatic drive_xfer(input logic [XL-1:0] a, input logic [XL-1:0] b,
                            input logic [1:0] s, input bit hold, output int last_cyc);
    logic [XL-1:0] r;
    r = model(a, b, s);
    for (int k = 0; k < NC; k++) begin
      rs_a = a[k*CS +: CS];
      rs_b = b[k*CS +: CS];
      sel  = s;
      req  = 1'b1;
      if (k == NC - 1) begin
        last_cyc = cyc;
        for (int j = 0; j < NC; j++) sb_q.push_back('{r[j*CS +: CS], cyc + 2 + j});
      end
      @(posedge clk);
      #1;
    end
    if (hold) begin
      for (int k = 0; k < NC + 1; k++) begin
        rs_a = CS'($urandom);
        rs_b = CS'($urandom);
        sel  = 2'($urandom);
        @(posedge clk);
        #1;
      end
    end else begin
      req  = 1'b0;
      rs_a = '0;
      rs_b = '0;
      sel  = '0;
    end
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 0;
    while (sb_q.size() != 0 && budget < 50) begin
      @(posedge clk);
      #1;
      budget++;
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (sb_q.size() !== 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d chunks still pending, expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 1'b0;
    rs_a = '0;
    rs_b = '0;
    sel = '0;
    #1;
    n_tests++;
    if (resp !== 1'b0 || res !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: resp=%b res=%h expected 0/0", resp, res);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_satadd();
    int l;
    drive_xfer(32'h0000_0003, 32'h0000_0005, 2'b00, 1'b0, l);
    wait_drain("satadd_small");
    drive_xfer(32'hFFFF_FFF0, 32'h0000_0020, 2'b00, 1'b0, l);
    wait_drain("satadd_sat");
    drive_xfer(32'hFFFF_FFFF, 32'h0000_0000, 2'b10, 1'b0, l);
    wait_drain("satadd_edge");
  endtask

  task automatic test_hamming();
    int l;
    drive_xfer(32'hFFFF_0000, 32'h0000_FFFF, 2'b11, 1'b0, l);
    wait_drain("hamming_full");
    drive_xfer(32'h1234_5678, 32'h1234_5678, 2'b01, 1'b0, l);
    wait_drain("hamming_zero");
  endtask

  task automatic test_abort();
    int l;
    for (int k = 0; k < 4; k++) begin
      rs_a = 4'hF;
      rs_b = 4'hF;
      sel  = 2'b00;
      req  = 1'b1;
      @(posedge clk);
      #1;
    end
    req = 1'b0;
    repeat (NC + 4) @(posedge clk);
    #1;
    drive_xfer(32'h0000_0001, 32'h0000_0001, 2'b00, 1'b0, l);
    wait_drain("abort_recover");
  endtask

  task automatic test_reset_mid_send();
    int l;
    drive_xfer(32'h8765_4321, 32'h0101_0101, 2'b00, 1'b0, l);
    while (cyc < l + 2 + 4) @(posedge clk);
    #2;
    n_tests++;
    if (resp !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_resp: resp=%b expected 1 on chunk 4", resp);
    end
    sb_q.delete();
    rst = 1'b1;
    #1;
    n_tests++;
    if (resp !== 1'b0 || res !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_send: resp=%b res=%h expected 0/0 before next edge", resp, res);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (NC + 2) @(posedge clk);
    #1;
    drive_xfer(32'h0000_00FF, 32'h0000_0F0F, 2'b01, 1'b0, l);
    wait_drain("rst_recover");
  endtask

  task automatic test_back_to_back();
    int l;
    drive_xfer(32'h7000_0000, 32'h1000_0000, 2'b00, 1'b1, l);
    drive_xfer(32'hAAAA_AAAA, 32'h5555_5555, 2'b01, 1'b0, l);
    wait_drain("back_to_back");
  endtask

  task automatic test_random();
    int l;
    logic [XL-1:0] a;
    logic [XL-1:0] b;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom;
      if (i[0]) a = a | 32'hF000_0000;
      drive_xfer(a, b, 2'($urandom), 1'b0, l);
      wait_drain("random");
    end
  endtask

  initial begin
    cyc     = 0;
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_satadd();
    test_hamming();
    test_abort();
    test_reset_mid_send();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
